// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared funct3 encodings and store-queue entry type
//
// Contents:
//   SB_ADDR_W / SB_DATA_W  entry field widths, matched to the data memory stage
//   LB..SW                 load/store funct3 encodings (instruction bits 14:12)
//   sb_entry_t             one queued store: addr, wdata, funct3, valid
package store_buffer_pkg;

    localparam int SB_ADDR_W = 9;
    localparam int SB_DATA_W = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] wdata;
        logic [2:0]           funct3;
        logic                 valid;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - circular store queue with head/tail pointers and occupancy count
//
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   push            write push_entry at tail (ignored when full)
//   push_entry      entry to enqueue
//   pop             retire the head entry (ignored when empty)
//   entries         raw storage, for the age-ordered hazard scan in the parent
//   head            index of the oldest entry
//   full, empty     occupancy flags
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  sb_entry_t                     push_entry,
    input  logic                          pop,
    output sb_entry_t [DEPTH-1:0]         entries,
    output logic [$clog2(DEPTH)-1:0]      head,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [PTR_W:0]        count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign entries = mem_q;
    assign head    = head_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else begin
            // With count strictly between 0 and DEPTH, tail != head, so a
            // simultaneous push and pop never touch the same slot.
            if (do_push) begin
                mem_q[tail_q] <= push_entry;
                tail_q        <= tail_q + 1'b1;
            end
            if (do_pop) begin
                mem_q[head_q].valid <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store queue front-end for the data memory stage
//
// Ports:
//   clk, reset              core clock, synchronous active-high reset
//   req_valid/we/addr/wdata/funct3
//                           MEM-stage request; req_ready=0 stalls the pipeline
//   load_valid, load_data   zero-latency load result (forwarded or from dm_rd)
//   drain_req, empty        fence handshake: block requests, report queue empty
//   dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_funct3, dm_rd
//                           data memory port; loads win, stores drain when idle
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DM_ADDRESS = SB_ADDR_W,
    parameter int DATA_W     = SB_DATA_W,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  req_ready,
    output logic                  load_valid,
    output logic [DATA_W-1:0]     load_data,
    input  logic                  drain_req,
    output logic                  empty,
    output logic                  dm_MemRead,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_funct3,
    input  logic [DATA_W-1:0]     dm_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             push_entry;
    sb_entry_t             head_entry;
    sb_entry_t             hit_entry;
    sb_entry_t             scan;
    logic [PTR_W-1:0]      head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  hit;
    logic                  fwd_ok;
    logic                  is_load;
    logic                  is_store;
    logic                  rd;

    assign is_load    = req_valid & ~req_we;
    assign is_store   = req_valid & req_we;
    assign push_entry = '{addr: req_addr, wdata: req_wdata, funct3: req_funct3, valid: 1'b1};
    assign head_entry = entries[head];

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .entries    (entries),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Walk oldest to newest so the last match is the youngest conflicting store.
    always_comb begin
        hit       = 1'b0;
        hit_entry = '0;
        scan      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan = entries[head + PTR_W'(i)];
            if (scan.valid && scan.addr[DM_ADDRESS-1:2] == req_addr[DM_ADDRESS-1:2]) begin
                hit       = 1'b1;
                hit_entry = scan;
            end
        end
    end

    // Only a full-word store to the exact address can supply a full-word load.
    assign fwd_ok = (hit_entry.addr == req_addr) && (hit_entry.funct3 == SW) &&
                    (req_funct3 == LW);

    always_comb begin
        req_ready   = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        rd          = 1'b0;
        dm_MemWrite = 1'b0;
        dm_a        = '0;
        dm_wd       = '0;
        dm_funct3   = '0;
        push        = 1'b0;
        pop         = 1'b0;
        if (!reset) begin
            if (is_load && !drain_req) begin
                if (!hit) begin
                    rd         = 1'b1;
                    dm_a       = req_addr;
                    dm_funct3  = req_funct3;
                    load_data  = dm_rd;
                    load_valid = 1'b1;
                    req_ready  = 1'b1;
                end else if (fwd_ok) begin
                    load_data  = hit_entry.wdata;
                    load_valid = 1'b1;
                    req_ready  = 1'b1;
                end
            end
            // full is the pre-drain occupancy: a drain this cycle frees no slot.
            if (is_store && !fifo_full && !drain_req) begin
                req_ready = 1'b1;
                push      = 1'b1;
            end
            // Any cycle without a load read lends the port to the oldest store.
            if (!rd && !fifo_empty) begin
                dm_MemWrite = 1'b1;
                dm_a        = head_entry.addr;
                dm_wd       = head_entry.wdata;
                dm_funct3   = head_entry.funct3;
                pop         = 1'b1;
            end
        end
    end

    assign dm_MemRead = rd;
    assign empty      = reset | fifo_empty;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized scoreboard bench for store_buffer
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [2:0]    req_funct3 = '0;
    logic          drain_req = 1'b0;
    logic          req_ready, load_valid, empty, dm_MemRead, dm_MemWrite;
    logic [DW-1:0] load_data, dm_wd, dm_rd;
    logic [AW-1:0] dm_a;
    logic [2:0]    dm_funct3;
    logic          mem_init = 1'b1;
    logic          done = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.DM_ADDRESS(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .req_ready(req_ready), .load_valid(load_valid), .load_data(load_data),
        .drain_req(drain_req), .empty(empty), .dm_MemRead(dm_MemRead),
        .dm_MemWrite(dm_MemWrite), .dm_a(dm_a), .dm_wd(dm_wd),
        .dm_funct3(dm_funct3), .dm_rd(dm_rd)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 29 + 7);
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            LB:      return {{24{w[7]}}, w[7:0]};
            LH:      return {{16{w[15]}}, w[15:0]};
            LBU:     return {24'd0, w[7:0]};
            LHU:     return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Environment data memory: byte array, little-endian, write committed on the edge.
    logic [7:0] env_mem [512];
    always_comb dm_rd = fmt({env_mem[dm_a + 9'd3], env_mem[dm_a + 9'd2],
                             env_mem[dm_a + 9'd1], env_mem[dm_a]}, dm_funct3);
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= init_byte(i);
        end else if (dm_MemWrite) begin
            env_mem[dm_a] <= dm_wd[7:0];
            if (dm_funct3 != SB) env_mem[dm_a + 9'd1] <= dm_wd[15:8];
            if (dm_funct3 == SW) begin
                env_mem[dm_a + 9'd2] <= dm_wd[23:16];
                env_mem[dm_a + 9'd3] <= dm_wd[31:24];
            end
        end
    end

    // Reference model: pending stores in program order plus the memory image they drain into.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    f3;
    } st_t;

    typedef struct packed {
        logic          rst, ready, lvalid, mread, mwrite, empty;
        logic [AW-1:0] ra;
        logic [2:0]    rf;
    } cyc_t;

    logic [7:0]  ref_mem [512];
    st_t         sq[$];
    cyc_t        exp_cyc[$];
    st_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
        return {ref_mem[a + 9'd3], ref_mem[a + 9'd2], ref_mem[a + 9'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input st_t s);
        ref_mem[s.addr] = s.data[7:0];
        if (s.f3 != SB) ref_mem[s.addr + 9'd1] = s.data[15:8];
        if (s.f3 == SW) begin
            ref_mem[s.addr + 9'd2] = s.data[23:16];
            ref_mem[s.addr + 9'd3] = s.data[31:24];
        end
    endtask

    // One pipeline cycle: drive the request and predict every observable effect.
    task automatic cyc(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] f,
                       input logic dr, input logic rs);
        cyc_t e;
        int   occ;
        int   ni;
        bit   mread;
        st_t  s;
        @(posedge clk);
        #1;
        reset = rs; req_valid = v; req_we = we; req_addr = a;
        req_wdata = d; req_funct3 = f; drain_req = dr;
        e = '0;
        ni = -1;
        mread = 1'b0;
        occ = sq.size();
        if (rs) begin
            e.rst = 1'b1;
            e.empty = 1'b1;
            sq.delete();
        end else begin
            e.empty = (occ == 0);
            if (v && !we && !dr) begin
                foreach (sq[i]) if (sq[i].addr[AW-1:2] == a[AW-1:2]) ni = i;
                if (ni < 0) begin
                    mread = 1'b1;
                    e.ready = 1'b1; e.lvalid = 1'b1; e.ra = a; e.rf = f;
                    exp_ld.push_back(fmt(ref_word(a), f));
                end else if (sq[ni].addr == a && sq[ni].f3 == SW && f == LW) begin
                    e.ready = 1'b1; e.lvalid = 1'b1;
                    exp_ld.push_back(sq[ni].data);
                end
            end
            e.mread = mread;
            if (!mread && occ > 0) begin
                e.mwrite = 1'b1;
                exp_wr.push_back(sq[0]);
                ref_write(sq[0]);
                void'(sq.pop_front());
            end
            if (v && we && !dr && occ < DEPTH) begin
                e.ready = 1'b1;
                s.addr = a; s.data = d; s.f3 = f;
                sq.push_back(s);
            end
        end
        exp_cyc.push_back(e);
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b required %b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops per-cycle, write and load expectations when the DUT presents them.
    always @(negedge clk) begin
        cyc_t e;
        st_t  w;
        if (exp_cyc.size() > 0) begin
            e = exp_cyc.pop_front();
            check1("req_ready", req_ready, e.ready);
            check1("load_valid", load_valid, e.lvalid);
            check1("dm_MemRead", dm_MemRead, e.mread);
            check1("dm_MemWrite", dm_MemWrite, e.mwrite);
            check1("empty", empty, e.empty);
            check1("rd_wr_exclusive", dm_MemRead & dm_MemWrite, 1'b0);
            if (e.mread) begin
                check32("dm_a_read", 32'(dm_a), 32'(e.ra));
                check32("dm_funct3_read", 32'(dm_funct3), 32'(e.rf));
            end
            if (!e.mread && !e.mwrite) begin
                check32("dm_a_idle", 32'(dm_a), 32'd0);
                check32("dm_wd_idle", dm_wd, 32'd0);
                check32("dm_funct3_idle", 32'(dm_funct3), 32'd0);
            end
            if (e.rst) check32("load_data_reset", load_data, 32'd0);
        end
        if (dm_MemWrite) begin
            if (exp_wr.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL drain: got write a=%h wd=%h required none", dm_a, dm_wd);
            end else begin
                w = exp_wr.pop_front();
                check32("drain_addr", 32'(dm_a), 32'(w.addr));
                check32("drain_data", dm_wd, w.data);
                check32("drain_funct3", 32'(dm_funct3), 32'(w.f3));
            end
        end
        if (load_valid) begin
            if (exp_ld.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL load: got load_data=%h required none", load_data);
            end else begin
                check32("load_data", load_data, exp_ld.pop_front());
            end
        end
        if (done) begin
            check32("writes_outstanding", 32'(exp_wr.size()), 32'd0);
            check32("loads_outstanding", 32'(exp_ld.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]    ld_f3 [5];
        logic [2:0]    st_f3 [3];
        logic [2:0]    f;
        logic [AW-1:0] a;
        logic          we;
        int            sz;
        ld_f3 = '{LB, LH, LW, LBU, LHU};
        st_f3 = '{SB, SH, SW};
        for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);

        cyc(0, 0, 9'h000, 0, 3'b000, 0, 1);
        mem_init = 1'b0;
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 1);
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 0);
        // Two stores then a read-back through memory.
        cyc(1, 1, 9'h010, 32'hDEADBEEF, SW, 0, 0);
        cyc(1, 1, 9'h020, 32'h12345678, SW, 0, 0);
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 0);
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 0);
        cyc(1, 0, 9'h010, 0, LW, 0, 0);
        // Back-to-back stores, each followed by an unrelated load.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, AW'(9'h080 + 4 * i), 32'hA0000000 + i, SW, 0, 0);
            cyc(1, 0, 9'h1F0, 0, LW, 0, 0);
        end
        // Exact forward, then partial conflict stall and retry.
        cyc(1, 1, 9'h044, 32'hCAFEBABE, SW, 0, 0);
        cyc(1, 0, 9'h044, 0, LW, 0, 0);
        cyc(1, 1, 9'h045, 32'h000000AB, SB, 0, 0);
        cyc(1, 0, 9'h044, 0, LW, 0, 0);
        cyc(1, 0, 9'h044, 0, LW, 0, 0);
        // Fence with a pending load, then the load after drain_req drops.
        cyc(1, 1, 9'h100, 32'h11111111, SW, 0, 0);
        cyc(1, 1, 9'h104, 32'h22222222, SW, 0, 0);
        cyc(1, 1, 9'h108, 32'h33333333, SW, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 9'h104, 0, LW, 1, 0);
        cyc(1, 0, 9'h104, 0, LW, 0, 0);
        // Reset while stores are queued.
        cyc(1, 1, 9'h140, 32'h55555555, SW, 0, 0);
        cyc(1, 1, 9'h144, 32'h66666666, SW, 0, 0);
        cyc(1, 0, 9'h144, 0, LW, 0, 1);
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 0);
        cyc(1, 0, 9'h144, 0, LW, 0, 0);
        // Randomized traffic over a narrow address window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                sz = $urandom_range(0, 2);
                f = st_f3[sz];
            end else begin
                f = ld_f3[$urandom_range(0, 4)];
                sz = (f == LW) ? 2 : ((f == LH || f == LHU) ? 1 : 0);
            end
            a = AW'({$urandom_range(0, 7), 2'b00});
            if ($urandom_range(0, 7) == 0) a = a + AW'(9'h100);
            if (sz == 0) a = a + AW'($urandom_range(0, 3));
            if (sz == 1) a = a + AW'(2 * $urandom_range(0, 1));
            cyc(1'($urandom_range(0, 3) != 0), we, a, $urandom, f,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));
        end
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 0);
        cyc(0, 0, 9'h000, 0, 3'b000, 0, 0);
        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
